// File: rtl/regs_pkg.sv
// Shared register-file constants and write-back requester indices for the NPC core.
package regs_pkg;
  localparam int unsigned RF_WIDTH      = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_NR_REGS    = 32;
  localparam int unsigned RF_ZERO_ADDR  = 0;

  localparam int unsigned WB_EXU = 0;
  localparam int unsigned WB_LSU = 1;
endpackage

// File: rtl/regs_wb_sched_if.sv
// Decode, write-back and regfile-write signals of the write-back scheduler.
interface regs_wb_sched_if
  import regs_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
);
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  raw_stall;
  logic                  wb0_valid;
  logic [ADDR_WIDTH-1:0] wb0_addr;
  logic [WIDTH-1:0]      wb0_data;
  logic                  wb0_ready;
  logic                  wb1_valid;
  logic [ADDR_WIDTH-1:0] wb1_addr;
  logic [WIDTH-1:0]      wb1_data;
  logic                  wb1_ready;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addrw;
  logic [WIDTH-1:0]      rf_dinw;
  logic                  proto_err;

  modport master (
    output iss_valid, iss_rd, rs1, rs2,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  iss_ready, raw_stall, wb0_ready, wb1_ready,
    input  rf_we, rf_addrw, rf_dinw, proto_err
  );

  modport slave (
    input  iss_valid, iss_rd, rs1, rs2,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output iss_ready, raw_stall, wb0_ready, wb1_ready,
    output rf_we, rf_addrw, rf_dinw, proto_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the port that did not win last time is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end
endmodule

// File: rtl/regs_wb_sched.sv
// Register-file write-back scheduler: arbitrates EXU/LSU write-backs onto the single
// write port and keeps a per-register busy scoreboard for RAW stalls and WAW blocking.
module regs_wb_sched
  import regs_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NR_REGS    = RF_NR_REGS
) (
  input  logic           clk,
  input  logic           rst,
  regs_wb_sched_if.slave bus
);
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [NR_REGS-1:0]    busy;
  logic [NR_REGS-1:0]    busy_nxt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;
  logic                  any_gnt;
  logic                  sel_nz;
  logic                  iss_fire;

  assign req = {bus.wb1_valid, bus.wb0_valid};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.wb0_ready = gnt[WB_EXU];
  assign bus.wb1_ready = gnt[WB_LSU];

  always_comb begin
    sel_addr = bus.wb0_addr;
    sel_data = bus.wb0_data;
    if (gnt[WB_LSU]) begin
      sel_addr = bus.wb1_addr;
      sel_data = bus.wb1_data;
    end
  end

  assign any_gnt  = |gnt;
  assign sel_nz   = sel_addr != ADDR_WIDTH'(RF_ZERO_ADDR);
  assign iss_fire = bus.iss_valid && bus.iss_ready &&
                    (bus.iss_rd != ADDR_WIDTH'(RF_ZERO_ADDR));

  // No bypass: busy stays set until the commit edge of the write.
  assign bus.iss_ready = !busy[bus.iss_rd];
  assign bus.raw_stall = busy[bus.rs1] | busy[bus.rs2];

  // Clear on commit, then set on issue so a same-register collision leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.rf_we) begin
      busy_nxt[bus.rf_addrw] = 1'b0;
    end
    if (iss_fire) begin
      busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[RF_ZERO_ADDR] = 1'b0;
  end

  // Writes to register 0 are consumed without reaching the regfile port.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_addrw  <= '0;
      bus.rf_dinw   <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      bus.rf_we <= any_gnt && sel_nz;
      if (any_gnt && sel_nz) begin
        bus.rf_addrw <= sel_addr;
        bus.rf_dinw  <= sel_data;
      end
      if (any_gnt && sel_nz && !busy[sel_addr]) begin
        bus.proto_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed per-cycle vector bench for regs_wb_sched, plus a bounded contention sequence.
module tb_regs_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  regs_wb_sched_if bus ();

  regs_wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          w0v;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    bit          w1v;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    bit          e_irdy;
    bit          e_stall;
    bit          e_g0;
    bit          e_g1;
    bit          e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    bit          e_pe;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   errs = 0;

  function automatic vec_t mk(
    input bit r, input bit iv, input int ird, input int rs1, input int rs2,
    input bit w0v, input int w0a, input logic [31:0] w0d,
    input bit w1v, input int w1a, input logic [31:0] w1d,
    input bit irdy, input bit stall, input bit g0, input bit g1,
    input bit we, input int a, input logic [31:0] d, input bit pe);
    vec_t v;
    v.r = r; v.iv = iv; v.ird = 5'(ird); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.w0v = w0v; v.w0a = 5'(w0a); v.w0d = w0d;
    v.w1v = w1v; v.w1a = 5'(w1a); v.w1d = w1d;
    v.e_irdy = irdy; v.e_stall = stall; v.e_g0 = g0; v.e_g1 = g1;
    v.e_we = we; v.e_a = 5'(a); v.e_d = d; v.e_pe = pe;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.r;
    bus.iss_valid = v.iv;
    bus.iss_rd    = v.ird;
    bus.rs1       = v.rs1;
    bus.rs2       = v.rs2;
    bus.wb0_valid = v.w0v;
    bus.wb0_addr  = v.w0a;
    bus.wb0_data  = v.w0d;
    bus.wb1_valid = v.w1v;
    bus.wb1_addr  = v.w1a;
    bus.wb1_data  = v.w1d;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int order[$];
    int cyc;
    bit p0;
    bit p1;

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //            r iv ird rs1 rs2 w0v w0a w0d  w1v w1a w1d  rdy stl g0 g1 we a  d  pe
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    // issue rd=5, RAW stall, commit of 0xDEADBEEF
    vecs.push_back(mk(0, 1, 5, 5, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5, 5, 0,  1, 5, 32'hDEADBEEF, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0, 0,  1, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 5, 5, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 5, 32'hDEADBEEF, 0));
    // reset, then rd=3/rd=4 with simultaneous write-backs
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 3, 4,  0, 0, 0,  0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 4,  1, 3, 32'h11, 1, 4, 32'h22,  1, 1, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 4,  0, 0, 0,  1, 4, 32'h22,  1, 1, 0, 1,  1, 3, 32'h11, 0));
    vecs.push_back(mk(0, 0, 0, 3, 4,  0, 0, 0,  0, 0, 0,  1, 1, 0, 0,  1, 4, 32'h22, 0));
    vecs.push_back(mk(0, 0, 0, 3, 4,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 4, 32'h22, 0));
    // issue 10..15, then six cycles of contention
    for (int k = 10; k <= 15; k++)
      vecs.push_back(mk(0, 1, k, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 4, 32'h22, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 10, 32'hA0, 1, 11, 32'hB1,  1, 0, 1, 0,  0, 4, 32'h22, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 12, 32'hA2, 1, 11, 32'hB1,  1, 0, 0, 1,  1, 10, 32'hA0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 12, 32'hA2, 1, 13, 32'hB3,  1, 0, 1, 0,  1, 11, 32'hB1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 14, 32'hA4, 1, 13, 32'hB3,  1, 0, 0, 1,  1, 12, 32'hA2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 14, 32'hA4, 1, 15, 32'hB5,  1, 0, 1, 0,  1, 13, 32'hB3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 32'hC0, 1, 15, 32'hB5,  1, 0, 0, 1,  1, 14, 32'hA4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 32'hC0, 0, 0, 0,  1, 0, 1, 0,  1, 15, 32'hB5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 15, 32'hB5, 0));
    // WAW block on rd=7; rd=0 always ready
    vecs.push_back(mk(0, 1, 7, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 15, 32'hB5, 0));
    vecs.push_back(mk(0, 1, 7, 7, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0,  0, 15, 32'hB5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  1, 7, 32'h77,  1, 0, 0, 1,  0, 15, 32'hB5, 0));
    vecs.push_back(mk(0, 0, 7, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 7, 32'h77, 0));
    vecs.push_back(mk(0, 0, 7, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 7, 32'h77, 0));
    // write to r0 is swallowed; write to idle r9 raises sticky proto_err
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 32'h55,  1, 0, 0, 1,  0, 7, 32'h77, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 9, 32'h99, 0, 0, 0,  1, 0, 1, 0,  0, 7, 32'h77, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 9, 32'h99, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 9, 32'h99, 1));
    // reset while busy[2] is set and its write-back is being granted
    vecs.push_back(mk(0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 9, 32'h99, 1));
    vecs.push_back(mk(1, 0, 0, 2, 0,  1, 2, 32'h2222, 0, 0, 0,  1, 1, 1, 0,  0, 9, 32'h99, 1));
    vecs.push_back(mk(0, 0, 2, 2, 5,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 32'hAA, 1, 0, 32'hBB,  1, 0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      nvec++;
      check("iss_ready", i, 32'(bus.iss_ready), 32'(vecs[i].e_irdy));
      check("raw_stall", i, 32'(bus.raw_stall), 32'(vecs[i].e_stall));
      check("wb0_ready", i, 32'(bus.wb0_ready), 32'(vecs[i].e_g0));
      check("wb1_ready", i, 32'(bus.wb1_ready), 32'(vecs[i].e_g1));
      check("rf_we", i, 32'(bus.rf_we), 32'(vecs[i].e_we));
      check("rf_addrw", i, 32'(bus.rf_addrw), 32'(vecs[i].e_a));
      check("rf_dinw", i, bus.rf_dinw, vecs[i].e_d);
      check("proto_err", i, 32'(bus.proto_err), 32'(vecs[i].e_pe));
    end

    // Requesters hold until granted; last grant was port 0, so LSU goes first.
    @(negedge clk); idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd20;
    @(negedge clk); bus.iss_rd = 5'd21;
    @(negedge clk); idle();
    bus.wb0_addr = 5'd20; bus.wb0_data = 32'h2020;
    bus.wb1_addr = 5'd21; bus.wb1_data = 32'h2121;
    p0 = 1'b1; p1 = 1'b1; cyc = 0;
    while ((p0 || p1) && cyc < 6) begin
      bus.wb0_valid = p0;
      bus.wb1_valid = p1;
      #1;
      if (bus.wb1_ready) begin order.push_back(1); p1 = 1'b0; end
      if (bus.wb0_ready) begin order.push_back(0); p0 = 1'b0; end
      cyc++;
      @(negedge clk);
    end
    nvec++;
    if (p0 || p1) begin
      errs++;
      $display("FAIL grant_timeout: pending p0=%0d p1=%0d after %0d cycles, expected none", p0, p1, cyc);
    end else begin
      check("grant_count", 100, 32'(order.size()), 32'd2);
      check("grant_first", 100, 32'(order[0]), 32'd1);
      check("grant_second", 100, 32'(order[order.size()-1]), 32'd0);
    end
    bus.wb0_valid = 1'b0; bus.wb1_valid = 1'b0;
    bus.rs1 = 5'd20; bus.rs2 = 5'd21;
    #1;
    nvec++;
    check("seq_rf_we", 101, 32'(bus.rf_we), 32'd1);
    check("seq_rf_addrw", 101, 32'(bus.rf_addrw), 32'd20);
    check("seq_rf_dinw", 101, bus.rf_dinw, 32'h2020);
    check("seq_stall_inflight", 101, 32'(bus.raw_stall), 32'd1);
    @(negedge clk); #1;
    nvec++;
    check("seq_rf_we_off", 102, 32'(bus.rf_we), 32'd0);
    check("seq_stall_clear", 102, 32'(bus.raw_stall), 32'd0);
    check("seq_proto_err", 102, 32'(bus.proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
Write-back scheduler and scoreboard for the 2-read/1-write general register file in the NPC core.
- Shares the single register-file write port between two write-back requesters: port 0 = EXU, port 1 = LSU.
- Uses round-robin arbitration and registers the selected write onto the regfile write port.
- Tracks a busy bit per register for issued-but-uncommitted destinations.
- Gives the decode stage a RAW stall signal and a WAW issue block.

Parameters:
WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
NR_REGS, 32, number of registers (busy vector length); register 0 is hardwired zero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_valid  in  1  decode issues an instruction that writes iss_rd
iss_rd  in  ADDR_WIDTH  destination register of the issuing instruction
iss_ready  out  1  issue accepted; 0 when busy[iss_rd]=1 (WAW block)
rs1  in  ADDR_WIDTH  source register 1 queried by decode
rs2  in  ADDR_WIDTH  source register 2 queried by decode
raw_stall  out  1  busy[rs1] | busy[rs2], combinational
wb0_valid  in  1  EXU write-back request
wb0_addr  in  ADDR_WIDTH  EXU destination
wb0_data  in  WIDTH  EXU result
wb0_ready  out  1  EXU request granted this cycle
wb1_valid  in  1  LSU write-back request
wb1_addr  in  ADDR_WIDTH  LSU destination
wb1_data  in  WIDTH  LSU result
wb1_ready  out  1  LSU request granted this cycle
rf_we  out  1  regfile write enable (registered)
rf_addrw  out  ADDR_WIDTH  regfile write address (registered)
rf_dinw  out  WIDTH  regfile write data (registered)
proto_err  out  1  sticky; set when a write-back targets a non-busy nonzero register

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - busy=0, rf_we=0, rf_addrw=0, rf_dinw=0.
  - last_grant=1, so port 0 wins the first contention.
  - proto_err=0.
- Arbitration (combinational, one grant per cycle):
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted.
  - last_grant updates to the granted port on every grant.
  - wbN_ready = grantN. A transfer occurs when valid & ready.
  - Ready never depends on ready; the requester holds valid/addr/data stable until granted.
- Write register:
  - A grant in cycle N gives rf_we=1 in cycle N+1, with rf_addrw/rf_dinw equal to the granted addr/data.
  - No grant in cycle N gives rf_we=0 in N+1. Address/data hold their previous values.
  - A granted write to address 0 is accepted (ready=1), but rf_we stays 0 and proto_err is not set.
- Scoreboard:
  - Set busy[iss_rd] at the edge ending a cycle with iss_valid & iss_ready & iss_rd!=0.
  - Clear busy[rf_addrw] at the edge ending a cycle with rf_we=1. The regfile commits on that same edge, so busy=0 and data are visible together from N+2.
  - busy[0] is always 0.
  - iss_ready = !busy[iss_rd]. iss_rd=0 is always ready.
  - Same-register set and clear in one cycle cannot occur legally, because the WAW block prevents it. If it occurs anyway, set wins.
- raw_stall:
  - Pure combinational lookup of busy.
  - No bypass: a register in flight stalls until its commit edge.
- proto_err:
  - Set when a granted write-back has a nonzero address whose busy bit is 0.
  - The write still proceeds.
  - Cleared only by rst.
- Reset mid-operation: pending grants and busy bits are discarded; rf_we=0 in the next cycle.

Decomposition:
- Shared package regs_pkg:
  - RF_WIDTH=32, RF_ADDR_WIDTH=5, RF_NR_REGS=32, RF_ZERO_ADDR=0.
  - Requester index constants WB_EXU=0, WB_LSU=1.
- One sub-module: rr_arb2, a 2-way round-robin arbiter holding last_grant, with inputs req[1:0] and output gnt[1:0].
- The scoreboard and write register stay in regs_wb_sched.

Test Plan:
- Reset, then issue rd=5, next cycle rs1=5 -> raw_stall=1; wb0 write (5, 0xDEADBEEF) granted cycle N -> rf_we=1, rf_addrw=5, rf_dinw=0xDEADBEEF in N+1; raw_stall=0 from N+2.
- Issue rd=3 and rd=4; wb0 (3,0x11) and wb1 (4,0x22) both valid every cycle after reset -> port 0 granted first, port 1 next; rf writes in order 3 then 4; only one grant per cycle.
- Continuous contention over 6 cycles with requesters re-presenting after each grant -> grants alternate 0,1,0,1,0,1.
- busy[7]=1 and iss_rd=7 -> iss_ready=0; after 7 commits -> iss_ready=1. iss_rd=0 always gives iss_ready=1, and busy[0] stays 0.
- wb1 write to addr 0 -> wb1_ready=1, rf_we=0, proto_err=0. wb0 write to non-busy reg 9 -> rf write occurs and proto_err=1 sticky until rst.
- busy[2]=1 with a wb0 grant in flight; assert rst -> next cycle rf_we=0, busy all 0, raw_stall=0 for rs1=2.
